sparc_ram_arbiter: RTL and testbench

//  Sole owner of the SPARC_RAM handshake port (mov / r_w / type / address / data, MOC).

---
 rtl/sparc_ram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sparc_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ram_arbiter.sv
// Two-port arbiter owning the SPARC_RAM mov/MOC handshake: round-robin grant,
// alignment check, single outstanding access bounded by a MOC timeout.
module sparc_ram_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              c_req,
  input  logic              c_rw,
  input  logic [1:0]        c_type,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_type,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              ram_mov,
  output logic              ram_rw,
  output logic [1:0]        ram_type,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_moc,
  output logic              owner_d
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_DONE   = 3'd2,
    S_ERR    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  // Reserved type and misaligned halfword/word accesses never reach the RAM.
  function automatic logic f_legal(input logic [1:0] t, input logic [1:0] a);
    logic ok;
    case (t)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [DATA_W-1:0] f_mask(input logic [1:0] t, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] m;
    case (t)
      2'b00:   m = {{(DATA_W-8){1'b0}}, 8'hFF};
      2'b01:   m = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      default: m = {DATA_W{1'b1}};
    endcase
    return d & m;
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic                r_rw;
  logic [1:0]          r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_c_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_owner_d;
  logic                r_last_d;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_grant_c;
  logic                w_grant_d;
  logic                w_grant;
  logic [1:0]          w_g_type;
  logic [ADDR_W-1:0]   w_g_addr;
  logic                w_mov;
  logic                w_done;
  logic                w_err;

  // Ties go to whichever port was not served last.
  assign w_grant_c = c_req & (~d_req | r_last_d);
  assign w_grant_d = d_req & (~c_req | ~r_last_d);
  assign w_grant   = w_grant_c | w_grant_d;
  assign w_g_type  = w_grant_d ? d_type : c_type;
  assign w_g_addr  = w_grant_d ? d_addr : c_addr;

  // State register
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next = f_legal(w_g_type, w_g_addr[1:0]) ? S_ACCESS : S_ERR;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (ram_moc) begin
          w_next = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_next = S_ERR;
        end else begin
          w_next = S_ACCESS;
        end
      end
      S_DONE, S_ERR, S_DRAIN: begin
        w_next = ram_moc ? S_DRAIN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the registered state and owner
  always_comb begin
    w_mov  = 1'b0;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_ACCESS: w_mov  = 1'b1;
      S_DONE:   w_done = 1'b1;
      S_ERR:    w_err  = 1'b1;
      default: begin
        w_mov  = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
      end
    endcase
  end

  // Request latch, access timer, read-data capture and round-robin history
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_rw      <= 1'b0;
      r_type    <= 2'b00;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b1;
      r_cnt     <= '0;
    end else begin
      if (r_state == S_IDLE && w_grant) begin
        r_rw      <= w_grant_d ? d_rw    : c_rw;
        r_type    <= w_g_type;
        r_addr    <= w_g_addr;
        r_wdata   <= w_grant_d ? d_wdata : c_wdata;
        r_owner_d <= w_grant_d;
        r_last_d  <= w_grant_d;
      end
      r_cnt <= (r_state == S_ACCESS) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == S_ACCESS && ram_moc && r_rw) begin
        if (r_owner_d) begin
          r_d_rdata <= f_mask(r_type, ram_rdata);
        end else begin
          r_c_rdata <= f_mask(r_type, ram_rdata);
        end
      end
    end
  end

  assign ram_mov   = w_mov;
  assign ram_rw    = r_rw;
  assign ram_type  = r_type;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign owner_d   = r_owner_d;
  assign c_ack     = w_done & ~r_owner_d;
  assign c_err     = w_err  & ~r_owner_d;
  assign d_ack     = w_done &  r_owner_d;
  assign d_err     = w_err  &  r_owner_d;
  assign c_rdata   = r_c_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_sparc_ram_arbiter.sv
// Bench for sparc_ram_arbiter: vector table of single accesses, a behavioural RAM
// with programmable MOC latency/hold, and a queue of expected completions.
module tb_sparc_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          Clk = 1'b0;
  logic          Clr = 1'b0;
  logic          c_req = 1'b0, c_rw = 1'b0, d_req = 1'b0, d_rw = 1'b0;
  logic [1:0]    c_type = 2'b00, d_type = 2'b00;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0, ram_rdata = '0;
  logic          ram_moc = 1'b0;
  logic [DW-1:0] c_rdata, d_rdata, ram_wdata;
  logic          c_ack, c_err, d_ack, d_err, ram_mov, ram_rw, owner_d;
  logic [1:0]    ram_type;
  logic [AW-1:0] ram_addr;

  sparc_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Clr(Clr),
    .c_req(c_req), .c_rw(c_rw), .c_type(c_type), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_err(c_err),
    .d_req(d_req), .d_rw(d_rw), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_type(ram_type), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_moc(ram_moc), .owner_d(owner_d)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          port_d;
    logic          err;
    logic          chk_rd;
    logic [31:0]   rdata;
    logic          rw;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } exp_t;

  typedef struct {
    logic          port_d;
    logic          rw;
    logic [1:0]    typ;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   ram_data;
    int            lat;
    logic          exp_err;
    logic [31:0]   exp_rd;
    int            exp_mov;
    logic          early;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   mov_total = 0;
  logic prev_mov = 1'b0;
  logic prev_moc = 1'b0;
  logic last_d = 1'b1;

  // RAM model: raises MOC after ram_lat mov cycles (0 = never), holds it ram_hold cycles after mov drops
  int ram_lat = 1;
  int ram_hold = 0;
  int mc = 0;
  int hc = 0;
  always begin
    @(posedge Clk);
    #2;
    if (!Clr) begin
      ram_moc = 1'b0; mc = 0; hc = 0;
    end else if (ram_mov) begin
      mc++; hc = 0;
      if (ram_lat != 0 && mc >= ram_lat) ram_moc = 1'b1;
    end else begin
      mc = 0;
      if (ram_moc) begin
        if (hc >= ram_hold) ram_moc = 1'b0;
        else hc++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One negedge sample: RAM-side checks and scoreboard pop on any completion
  task automatic tick();
    exp_t e;
    @(negedge Clk);
    if (ram_mov) begin
      mov_total++;
      if (!prev_mov) chk("no_access_while_moc", {31'd0, prev_moc}, 32'd0);
      if (q.size() > 0) begin
        chk("ram_addr", {23'd0, ram_addr}, {23'd0, q[0].addr});
        chk("ram_rw", {31'd0, ram_rw}, {31'd0, q[0].rw});
        if (!q[0].rw) chk("ram_wdata", ram_wdata, q[0].wdata);
      end
    end
    if (c_ack | c_err | d_ack | d_err) begin
      chk("ack_err_excl", {31'd0, (c_ack & c_err) | (d_ack & d_err)}, 32'd0);
      chk("one_port", {31'd0, (c_ack | c_err) & (d_ack | d_err)}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("port", {31'd0, d_ack | d_err}, {31'd0, e.port_d});
        chk("owner_d", {31'd0, owner_d}, {31'd0, e.port_d});
        chk("is_err", {31'd0, c_err | d_err}, {31'd0, e.err});
        if (e.chk_rd) chk("rdata", e.port_d ? d_rdata : c_rdata, e.rdata);
      end
    end
    prev_mov = ram_mov;
    prev_moc = ram_moc;
  endtask

  task automatic wait_done(input int n, input logic auto_drop, input int maxcyc);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < maxcyc) begin
      tick();
      cyc++;
      if (c_ack | c_err | d_ack | d_err) seen++;
      if (auto_drop && (c_ack | c_err)) c_req = 1'b0;
      if (auto_drop && (d_ack | d_err)) d_req = 1'b0;
    end
    if (seen < n) begin
      chk("completion_timeout", 32'(seen), 32'(n));
      q.delete();
    end
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (ram_moc && n < 20) begin tick(); n++; end
    tick();
    tick();
  endtask

  function automatic exp_t mk_exp(input logic pd, input logic rw, input logic err,
                                  input logic [31:0] rd, input logic [AW-1:0] a, input logic [31:0] wd);
    exp_t e;
    e.port_d = pd; e.err = err; e.chk_rd = rw & ~err; e.rdata = rd;
    e.rw = rw; e.addr = a; e.wdata = wd;
    return e;
  endfunction

  function automatic vec_t mk(input logic pd, input logic rw, input logic [1:0] t, input logic [AW-1:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int lat,
                              input logic err, input logic [31:0] xrd, input int xmov, input logic early);
    vec_t v;
    v.port_d = pd; v.rw = rw; v.typ = t; v.addr = a; v.wdata = wd; v.ram_data = rd;
    v.lat = lat; v.exp_err = err; v.exp_rd = xrd; v.exp_mov = xmov; v.early = early;
    return v;
  endfunction

  task automatic run_single(input vec_t v);
    int m0;
    ram_rdata = v.ram_data;
    ram_lat = v.lat;
    ram_hold = 0;
    q.push_back(mk_exp(v.port_d, v.rw, v.exp_err, v.exp_rd, v.addr, v.wdata));
    m0 = mov_total;
    if (v.port_d) begin
      d_rw = v.rw; d_type = v.typ; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      c_rw = v.rw; c_type = v.typ; c_addr = v.addr; c_wdata = v.wdata; c_req = 1'b1;
    end
    last_d = v.port_d;
    if (v.early) begin
      tick();
      c_req = 1'b0;
      d_req = 1'b0;
    end
    wait_done(1, 1'b1, 60);
    chk("mov_cycles", 32'(mov_total - m0), 32'(v.exp_mov));
    settle();
  endtask

  vec_t vt[11];
  logic first_d;
  logic pd;
  int   m0;

  initial begin
    // port, rw, type, addr, wdata, ram data, MOC latency (0 = never), err, rdata, mov cycles, early drop
    vt[0]  = mk(1'b0, 1'b1, 2'b10, 9'h004, 32'h0, 32'h8A0F_1234, 3, 1'b0, 32'h8A0F_1234, 3, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, 2'b01, 9'h006, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_BEEF, 1, 1'b0);
    vt[2]  = mk(1'b1, 1'b1, 2'b10, 9'h010, 32'h0, 32'h1234_5678, 2, 1'b0, 32'h1234_5678, 2, 1'b0);
    vt[3]  = mk(1'b1, 1'b1, 2'b01, 9'h003, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 0, 1'b0);
    vt[4]  = mk(1'b1, 1'b1, 2'b11, 9'h000, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 0, 1'b0);
    vt[5]  = mk(1'b0, 1'b1, 2'b10, 9'h002, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 0, 1'b0);
    vt[6]  = mk(1'b0, 1'b0, 2'b10, 9'h008, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 32'h0, 2, 1'b1);
    vt[7]  = mk(1'b1, 1'b0, 2'b00, 9'h005, 32'hFFFF_FFA5, 32'h0, 1, 1'b0, 32'h0, 1, 1'b0);
    vt[8]  = mk(1'b0, 1'b1, 2'b00, 9'h0FF, 32'h0, 32'hABCD_EF99, 1, 1'b0, 32'h0000_0099, 1, 1'b0);
    vt[9]  = mk(1'b0, 1'b1, 2'b01, 9'h001, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 0, 1'b0);
    vt[10] = mk(1'b0, 1'b1, 2'b10, 9'h00C, 32'h0, 32'h7777_7777, 0, 1'b1, 32'h0, TO, 1'b0);

    // Reset with a pending C request: everything quiet, then grant right after release
    c_rw = 1'b1; c_type = 2'b10; c_addr = 9'h00C; c_req = 1'b1;
    ram_rdata = 32'h0BAD_F00D; ram_lat = 1;
    tick(); tick();
    chk("rst_mov", {31'd0, ram_mov}, 32'd0);
    chk("rst_acks", {28'd0, c_ack, c_err, d_ack, d_err}, 32'd0);
    chk("rst_owner", {31'd0, owner_d}, 32'd0);
    chk("rst_ram_bus", {20'd0, ram_rw, ram_type, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_rdata", c_rdata | d_rdata, 32'd0);
    q.push_back(mk_exp(1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, 9'h00C, 32'h0));
    Clr = 1'b1;
    tick();
    chk("first_grant_mov", {31'd0, ram_mov}, 32'd1);
    last_d = 1'b0;
    wait_done(1, 1'b1, 40);
    settle();

    for (int i = 0; i < 11; i++) run_single(vt[i]);

    // Both ports hammer writes: grants must alternate starting with the port not served last
    ram_lat = 1; ram_hold = 0;
    first_d = ~last_d;
    for (int i = 0; i < 4; i++) begin
      pd = first_d ^ (i % 2 == 1);
      q.push_back(pd ? mk_exp(1'b1, 1'b0, 1'b0, 32'h0, 9'h030, 32'h2222_2222)
                     : mk_exp(1'b0, 1'b0, 1'b0, 32'h0, 9'h020, 32'h1111_1111));
    end
    c_rw = 1'b0; c_type = 2'b10; c_addr = 9'h020; c_wdata = 32'h1111_1111;
    d_rw = 1'b0; d_type = 2'b10; d_addr = 9'h030; d_wdata = 32'h2222_2222;
    m0 = mov_total;
    c_req = 1'b1; d_req = 1'b1;
    wait_done(4, 1'b0, 100);
    chk("alt_mov_cycles", 32'(mov_total - m0), 32'd4);
    last_d = ~first_d;
    settle();

    // Loader byte readback: upper RAM bits must be masked off
    for (int a = 0; a <= 230; a++)
      run_single(mk(1'b1, 1'b1, 2'b00, 9'(a), 32'h0, 32'hFFFF_FF5A, 1, 1'b0, 32'h0000_005A, 1, 1'b0));

    // MOC lingers after D's access; C's access must wait for it to fall
    ram_rdata = 32'hFFFF_FF5A; ram_lat = 1; ram_hold = 2;
    q.push_back(mk_exp(1'b1, 1'b1, 1'b0, 32'h0000_005A, 9'h010, 32'h0));
    q.push_back(mk_exp(1'b0, 1'b1, 1'b0, 32'hFFFF_FF5A, 9'h040, 32'h0));
    d_rw = 1'b1; d_type = 2'b00; d_addr = 9'h010; d_req = 1'b1;
    m0 = mov_total;
    tick();
    c_rw = 1'b1; c_type = 2'b10; c_addr = 9'h040; c_req = 1'b1;
    wait_done(2, 1'b1, 60);
    chk("drain_mov_cycles", 32'(mov_total - m0), 32'd2);
    settle();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
